host_msix_ctrl: RTL and testbench

- MSI-X interrupt controller ahead of the host memory write path.
- Collects interrupt pulses from NUM_VEC device sources, holds per-vector pending bits and a programmable vector table (address and data), and applies masking.
- Picks one deliverable vector round-robin and issues a single DW posted write (table address, table data) to the host memory write channel, then waits for completion.
- Write stream format matches what the host model's MSI-X detector consumes, e.g. addr 0x1 / data 0x12345678.

---
 rtl/host_msix_pkg.sv | 23 ++
 rtl/host_msix_rr_arb.sv | 32 +++
 rtl/host_msix_ctrl.sv | 156 +++++++++++++++
 tb/tb_host_msix_ctrl.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/host_msix_pkg.sv
// Shared types and constants for the MSI-X interrupt controller.
package host_msix_pkg;

  typedef logic [63:0] u64_t;
  typedef logic [31:0] u32_t;

  // Controller FSM states
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StArb  = 2'd1,
    StSend = 2'd2,
    StWait = 2'd3
  } msix_state_e;

  // One vector table entry: message address and message data
  typedef struct packed {
    u64_t addr;
    u32_t data;
  } msix_vec_entry_t;

  localparam logic [15:0] COALESCE_MAX = 16'hFFFF;

endpackage

// File: rtl/host_msix_rr_arb.sv
// Combinational round-robin arbiter: first eligible vector at or after rr_ptr, wrapping.
module host_msix_rr_arb
  import host_msix_pkg::*;
#(
  parameter int unsigned NUM_VEC = 8,
  localparam int unsigned IdxW = (NUM_VEC > 1) ? $clog2(NUM_VEC) : 1
) (
  input  logic [NUM_VEC-1:0] eligible,
  input  logic [IdxW-1:0]    rr_ptr,
  output logic [NUM_VEC-1:0] grant,
  output logic [IdxW-1:0]    grant_idx,
  output logic               any_valid
);

  // Scan NUM_VEC positions starting at rr_ptr; the first hit wins.
  always_comb begin
    int unsigned j;
    grant     = '0;
    grant_idx = '0;
    any_valid = 1'b0;
    j         = 0;
    for (int unsigned k = 0; k < NUM_VEC; k++) begin
      j = (32'(rr_ptr) + k) % NUM_VEC;
      if (!any_valid && eligible[j]) begin
        any_valid = 1'b1;
        grant[j]  = 1'b1;
        grant_idx = IdxW'(j);
      end
    end
  end

endmodule

// File: rtl/host_msix_ctrl.sv
// MSI-X controller: pending/mask tracking, vector table, round-robin delivery of one
// single-DW posted write per interrupt, completion wait with timeout.
module host_msix_ctrl
  import host_msix_pkg::*;
#(
  parameter int unsigned NUM_VEC     = 8,
  parameter int unsigned ADDR_W      = 64,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned TIMEOUT_CYC = 1024,
  localparam int unsigned IdxW = (NUM_VEC > 1) ? $clog2(NUM_VEC) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               msix_enable,
  input  logic [NUM_VEC-1:0] intr_req,
  input  logic [NUM_VEC-1:0] vec_mask,
  input  logic               tbl_wr_en,
  input  logic [IdxW-1:0]    tbl_wr_idx,
  input  logic [ADDR_W-1:0]  tbl_wr_addr,
  input  logic [DATA_W-1:0]  tbl_wr_data,
  output logic               wr_valid,
  input  logic               wr_ready,
  output logic [ADDR_W-1:0]  wr_addr,
  output logic [DATA_W-1:0]  wr_data,
  input  logic               wr_done,
  output logic [NUM_VEC-1:0] pending,
  output logic               busy,
  output logic               intr_sent,
  output logic [15:0]        coalesce_cnt,
  output logic               timeout_err
);

  localparam int unsigned TimerW = $clog2(TIMEOUT_CYC + 1);

  msix_state_e        state_q, state_d;
  logic [NUM_VEC-1:0] pending_q, pending_d;
  logic [NUM_VEC-1:0] mask_q;
  logic [NUM_VEC-1:0] eligible;
  logic [NUM_VEC-1:0] clr;
  logic [NUM_VEC-1:0] grant_q;
  logic [IdxW-1:0]    rr_ptr_q;
  logic [ADDR_W-1:0]  wr_addr_q;
  logic [DATA_W-1:0]  wr_data_q;
  logic [15:0]        coalesce_q;
  logic [TimerW-1:0]  timer_q;
  logic               timeout_q;
  logic               coal_hit;
  logic               arb_load;
  logic               timeout_set;

  logic [NUM_VEC-1:0] arb_grant;
  logic [IdxW-1:0]    arb_idx;
  logic               arb_valid;

  msix_vec_entry_t    table_q [NUM_VEC];

  // Mask is registered, so an unmask becomes visible to arbitration one cycle later.
  assign eligible = pending_q & ~mask_q;
  assign clr      = (state_q == StSend && wr_ready) ? grant_q : '0;
  // A request landing on a vector being cleared this cycle simply re-arms it.
  assign coal_hit = |(intr_req & pending_q & ~clr);
  assign pending_d = (pending_q & ~clr) | intr_req;

  host_msix_rr_arb #(
    .NUM_VEC (NUM_VEC)
  ) u_rr_arb (
    .eligible  (eligible),
    .rr_ptr    (rr_ptr_q),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .any_valid (arb_valid)
  );

  // Next-state logic for the delivery FSM.
  always_comb begin
    state_d     = state_q;
    arb_load    = 1'b0;
    timeout_set = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (msix_enable && |eligible) state_d = StArb;
      end
      StArb: begin
        // Eligibility can vanish (mask) between IDLE and ARB; fall back to IDLE then.
        if (arb_valid) begin
          state_d  = StSend;
          arb_load = 1'b1;
        end else begin
          state_d = StIdle;
        end
      end
      StSend: begin
        if (wr_ready) state_d = StWait;
      end
      StWait: begin
        if (wr_done) begin
          state_d = StIdle;
        end else if (timer_q == TimerW'(TIMEOUT_CYC - 1)) begin
          state_d     = StIdle;
          timeout_set = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Control state: FSM, pending, grant snapshot, RR pointer, counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      pending_q  <= '0;
      mask_q     <= '0;
      grant_q    <= '0;
      rr_ptr_q   <= '0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      coalesce_q <= '0;
      timer_q    <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      mask_q    <= vec_mask;
      timeout_q <= timeout_q | timeout_set;
      if (coal_hit && coalesce_q != COALESCE_MAX) coalesce_q <= coalesce_q + 16'd1;
      timer_q <= (state_q == StWait) ? timer_q + TimerW'(1) : '0;
      if (arb_load) begin
        grant_q   <= arb_grant;
        wr_addr_q <= ADDR_W'(table_q[arb_idx].addr);
        wr_data_q <= DATA_W'(table_q[arb_idx].data);
        if (32'(arb_idx) == NUM_VEC - 1) rr_ptr_q <= '0;
        else                             rr_ptr_q <= arb_idx + IdxW'(1);
      end
    end
  end

  // Vector table; the held wr_addr/wr_data are unaffected by later writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_VEC; i++) table_q[i] <= '0;
    end else if (tbl_wr_en && (32'(tbl_wr_idx) < NUM_VEC)) begin
      table_q[tbl_wr_idx].addr <= 64'(tbl_wr_addr);
      table_q[tbl_wr_idx].data <= 32'(tbl_wr_data);
    end
  end

  assign wr_valid     = (state_q == StSend);
  assign wr_addr      = wr_addr_q;
  assign wr_data      = wr_data_q;
  assign pending      = pending_q;
  assign busy         = (state_q != StIdle);
  assign intr_sent    = (state_q == StWait) && wr_done;
  assign coalesce_cnt = coalesce_q;
  assign timeout_err  = timeout_q;

endmodule

// File: tb/tb_host_msix_ctrl.sv
// Directed plus randomized bench for host_msix_ctrl with a transaction-level reference model.
module tb_host_msix_ctrl;

  localparam int NV = 6;
  localparam int TO = 1024;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          msix_enable = 1'b0;
  logic [NV-1:0] intr_req = '0;
  logic [NV-1:0] vec_mask = '0;
  logic          tbl_wr_en = 1'b0;
  logic [2:0]    tbl_wr_idx = '0;
  logic [63:0]   tbl_wr_addr = '0;
  logic [31:0]   tbl_wr_data = '0;
  logic          wr_valid;
  logic          wr_ready = 1'b0;
  logic [63:0]   wr_addr;
  logic [31:0]   wr_data;
  logic          wr_done = 1'b0;
  logic [NV-1:0] pending;
  logic          busy;
  logic          intr_sent;
  logic [15:0]   coalesce_cnt;
  logic          timeout_err;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [63:0]   m_addr [NV];
  logic [31:0]   m_data [NV];
  logic [NV-1:0] m_pend;
  int            m_rr;
  logic [15:0]   m_coal;

  host_msix_ctrl #(
    .NUM_VEC     (NV),
    .ADDR_W      (64),
    .DATA_W      (32),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .msix_enable  (msix_enable),
    .intr_req     (intr_req),
    .vec_mask     (vec_mask),
    .tbl_wr_en    (tbl_wr_en),
    .tbl_wr_idx   (tbl_wr_idx),
    .tbl_wr_addr  (tbl_wr_addr),
    .tbl_wr_data  (tbl_wr_data),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .wr_done      (wr_done),
    .pending      (pending),
    .busy         (busy),
    .intr_sent    (intr_sent),
    .coalesce_cnt (coalesce_cnt),
    .timeout_err  (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NV; i++) begin
      m_addr[i] = '0;
      m_data[i] = '0;
    end
    m_pend = '0;
    m_rr   = 0;
    m_coal = '0;
  endtask

  task automatic model_req(input logic [NV-1:0] bits);
    if (|(bits & m_pend) && m_coal != 16'hFFFF) m_coal = m_coal + 16'd1;
    m_pend = m_pend | bits;
  endtask

  // Next vector to deliver: first unmasked pending vector at or after m_rr, wrapping.
  function automatic int next_grant();
    logic [NV-1:0] e;
    e = m_pend & ~vec_mask;
    for (int k = 0; k < NV; k++) begin
      if (e[(m_rr + k) % NV]) return (m_rr + k) % NV;
    end
    return -1;
  endfunction

  task automatic tbl_write(input int idx, input logic [63:0] a, input logic [31:0] d);
    tbl_wr_en   = 1'b1;
    tbl_wr_idx  = 3'(idx);
    tbl_wr_addr = a;
    tbl_wr_data = d;
    tick();
    tbl_wr_en = 1'b0;
    if (idx < NV) begin
      m_addr[idx] = a;
      m_data[idx] = d;
    end
  endtask

  task automatic pulse(input logic [NV-1:0] bits);
    intr_req = bits;
    model_req(bits);
    tick();
    intr_req = '0;
  endtask

  task automatic wait_valid(output int cnt);
    cnt = 0;
    while (wr_valid !== 1'b1 && cnt < 40) begin
      tick();
      cnt++;
    end
  endtask

  // Host side of one delivery: accept the write, then complete it.
  task automatic serve(input string tag, input int rdy_dly, input int done_dly);
    int g;
    int cnt;
    logic [63:0] a0;
    logic [31:0] d0;
    g = next_grant();
    chk({tag, "_has_grant"}, 64'(g >= 0), 64'd1);
    if (g < 0) return;
    wait_valid(cnt);
    chk({tag, "_valid"}, 64'(wr_valid), 64'd1);
    chk({tag, "_addr"}, wr_addr, m_addr[g]);
    chk({tag, "_data"}, 64'(wr_data), 64'(m_data[g]));
    a0 = wr_addr;
    d0 = wr_data;
    repeat (rdy_dly) tick();
    if (rdy_dly > 0)
      chk({tag, "_hold"}, 64'({wr_valid, wr_addr == a0, wr_data == d0}), 64'b111);
    wr_ready = 1'b1;
    tick();
    wr_ready = 1'b0;
    m_pend[g] = 1'b0;
    m_rr = (g + 1) % NV;
    #1;
    chk({tag, "_pend_clr"}, 64'(pending), 64'(m_pend));
    repeat (done_dly) tick();
    wr_done = 1'b1;
    #1;
    chk({tag, "_sent"}, 64'(intr_sent), 64'd1);
    tick();
    wr_done = 1'b0;
    #1;
    chk({tag, "_sent_end"}, 64'(intr_sent), 64'd0);
    chk({tag, "_idle"}, 64'(busy), 64'd0);
  endtask

  // Expect the controller to stay idle for n cycles.
  task automatic quiet(input string tag, input int n);
    int b;
    b = 0;
    for (int i = 0; i < n; i++) begin
      if (busy !== 1'b0) b++;
      tick();
    end
    chk(tag, 64'(b), 64'd0);
  endtask

  initial begin
    int cnt;
    logic stable;
    logic sent;
    logic [63:0] a0;
    logic [31:0] d0;
    logic [NV-1:0] bits;
    int k;
    int extra;

    model_reset();
    #3;
    chk("rst_valid", 64'(wr_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_pending", 64'(pending), 64'd0);
    chk("rst_coal", 64'(coalesce_cnt), 64'd0);
    chk("rst_misc", 64'({intr_sent, timeout_err, wr_addr, wr_data}), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Basic delivery and latency
    tbl_write(0, 64'h1, 32'h12345678);
    msix_enable = 1'b1;
    repeat (3) tick();
    intr_req = 6'b000001;
    model_req(6'b000001);
    tick();
    intr_req = '0;
    chk("lat_pend", 64'(pending), 64'b000001);
    tick();
    chk("lat_arb", 64'({busy, wr_valid}), 64'b10);
    tick();
    chk("lat_send", 64'(wr_valid), 64'd1);
    serve("basic", 0, 2);

    // Random table contents; index beyond NUM_VEC must be ignored
    for (int i = 0; i < NV; i++) tbl_write(i, {$urandom, $urandom}, $urandom);
    tbl_write(7, 64'hDEAD_BEEF_0000_0007, 32'hBAD0_0007);

    // Bring rr pointer to 0, then ordered multi-vector deliveries
    pulse(6'b100000);
    serve("rr_home", 0, 1);
    pulse(6'b101001);
    while (next_grant() >= 0) serve("multi035", 0, 1);
    pulse(6'b100001);
    while (next_grant() >= 0) serve("multi05", 1, 0);

    // Randomized subsets
    for (int r = 0; r < 6; r++) begin
      bits = NV'($urandom_range(1, (1 << NV) - 1));
      pulse(bits);
      while (next_grant() >= 0) serve("rnd", $urandom_range(0, 3), $urandom_range(0, 3));
      chk("rnd_pend", 64'(pending), 64'(m_pend));
    end

    // Coalescing: three pulses to vector 1 while pending
    pulse(6'b000010);
    pulse(6'b000010);
    pulse(6'b000010);
    chk("coal_cnt", 64'(coalesce_cnt), 64'(m_coal));
    serve("coal", 0, 1);
    quiet("coal_single", 20);

    for (int r = 0; r < 3; r++) begin
      k = $urandom_range(0, NV - 1);
      extra = $urandom_range(1, 4);
      for (int p = 0; p <= extra; p++) pulse(NV'(1 << k));
      chk("rcoal_cnt", 64'(coalesce_cnt), 64'(m_coal));
      serve("rcoal", 0, 1);
      quiet("rcoal_single", 5);
    end

    // Request in the same cycle as the clear: set wins, not coalesced
    pulse(6'b000100);
    wait_valid(cnt);
    chk("setclr_valid", 64'(wr_valid), 64'd1);
    chk("setclr_addr", wr_addr, m_addr[2]);
    wr_ready = 1'b1;
    intr_req = 6'b000100;
    tick();
    wr_ready = 1'b0;
    intr_req = '0;
    m_rr = 3;
    #1;
    chk("setclr_pend", 64'(pending), 64'(m_pend));
    chk("setclr_coal", 64'(coalesce_cnt), 64'(m_coal));
    wr_done = 1'b1;
    tick();
    wr_done = 1'b0;
    serve("setclr_again", 0, 1);

    // Masking holds the vector pending; unmask delivers three cycles later
    vec_mask = 6'b000100;
    tick();
    pulse(6'b000100);
    quiet("mask_hold", 100);
    chk("mask_pend", 64'(pending), 64'(m_pend));
    vec_mask = '0;
    wait_valid(cnt);
    chk("unmask_lat", 64'(cnt), 64'd3);
    serve("unmask", 0, 1);

    // Enable falling mid-transaction: it completes, no new arbitration
    pulse(6'b010010);
    wait_valid(cnt);
    msix_enable = 1'b0;
    serve("en_drop", 2, 3);
    quiet("en_off", 10);
    chk("en_off_pend", 64'(pending), 64'(m_pend));
    msix_enable = 1'b1;
    while (next_grant() >= 0) serve("en_back", 0, 0);

    // wr_done outside WAIT is ignored
    wr_done = 1'b1;
    #1;
    chk("stray_done", 64'(intr_sent), 64'd0);
    tick();
    wr_done = 1'b0;
    chk("stray_idle", 64'(busy), 64'd0);

    // Stalled accept, table rewrite mid-SEND, then completion timeout
    pulse(6'b000001);
    wait_valid(cnt);
    chk("to_addr", wr_addr, m_addr[0]);
    chk("to_data", 64'(wr_data), 64'(m_data[0]));
    a0 = wr_addr;
    d0 = wr_data;
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (i == 10) tbl_write(0, {$urandom, $urandom}, $urandom);
      else tick();
      if (!(wr_valid === 1'b1 && wr_addr === a0 && wr_data === d0)) stable = 1'b0;
    end
    chk("to_stable", 64'(stable), 64'd1);
    chk("to_err_pre", 64'(timeout_err), 64'd0);
    wr_ready = 1'b1;
    tick();
    wr_ready = 1'b0;
    m_pend[0] = 1'b0;
    m_rr = 1;
    cnt = 0;
    sent = 1'b0;
    while (busy === 1'b1 && cnt < TO + 100) begin
      cnt++;
      if (intr_sent === 1'b1) sent = 1'b1;
      tick();
    end
    chk("to_wait_len", 64'(cnt), 64'(TO));
    chk("to_err", 64'(timeout_err), 64'd1);
    chk("to_no_sent", 64'(sent), 64'd0);
    pulse(6'b000001);
    serve("after_to", 0, 1);
    chk("to_sticky", 64'(timeout_err), 64'd1);

    // Asynchronous reset during SEND
    pulse(6'b001000);
    pulse(6'b001000);
    wait_valid(cnt);
    chk("prerst_valid", 64'(wr_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 64'(wr_valid), 64'd0);
    chk("arst_pending", 64'(pending), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_coal", 64'(coalesce_cnt), 64'd0);
    chk("arst_err", 64'(timeout_err), 64'd0);
    tick();
    tick();
    rst_n = 1'b1;
    model_reset();
    tick();
    pulse(6'b000100);
    serve("post_rst_blank", 0, 1);
    tbl_write(4, 64'h0000_0001_2345_6780, 32'hCAFE_F00D);
    pulse(6'b010000);
    serve("post_rst", 1, 1);
    chk("final_coal", 64'(coalesce_cnt), 64'(m_coal));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
